// File: rtl/niossoc_pio_pkg.sv
// Shared definitions for the NiosSoc PIO blocks: register addresses, edge-type codes, clog2.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package niossoc_pio_pkg;

  // Avalon-MM register map (2-bit word address)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/niossoc_pio_debounce.sv
// Single-bit input conditioner: SYNC_STAGES-flop synchroniser, optional stable-count debounce.
// Latency: SYNC_STAGES cycles in->f_bit; plus DEBOUNCE_CYCLES when PIO_DEBOUNCE_EN is defined.
// Backpressure: none; free-running sampler.
//
// Ports: clk, reset (sync, active-high), in_bit (asynchronous pin), f_bit (filtered level).
// Build option: PIO_DEBOUNCE_EN adds the per-bit debounce counter; without it f_bit is the
// synchroniser output and no counter exists.
module niossoc_pio_debounce
  import niossoc_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic f_bit
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("niossoc_pio_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("niossoc_pio_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   synced;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Reset loads the live pin level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{in_bit}};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             synced_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             f_q;
  logic             f_d;

  // The stage feeding 'synced' is the next synced sample; if it differs, the level is about
  // to move again, so the count restarts. Counting from the first cycle the new level is
  // seen makes the added delay exactly DEBOUNCE_CYCLES.
  assign synced_next = sync_q[SYNC_STAGES-2];

  always_comb begin
    cnt_d = '0;
    f_d   = f_q;
    if ((synced != f_q) && (synced_next == synced)) begin
      if (cnt_q == CNT_LAST) begin
        f_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      f_q   <= in_bit;
    end else begin
      cnt_q <= cnt_d;
      f_q   <= f_d;
    end
  end

  assign f_bit = f_q;
`else
  assign f_bit = synced;
`endif

endmodule

// File: rtl/niossoc_button_pio.sv
// Avalon-MM input PIO: synchronised pin state, sticky per-bit edge capture, masked level irq.
// Latency: readdata 1 cycle after address; pin change to EDGECAP SYNC_STAGES+1 cycles (+DEBOUNCE_CYCLES).
// Backpressure: none; slave always accepts, no waitrequest.
//
// Ports: clk, reset (sync, active-high); address[1:0], chipselect, write_n, writedata[31:0]
// (Avalon slave inputs); in_port[WIDTH-1:0] (async pins); readdata[31:0] (registered); irq.
// Build option: PIO_DEBOUNCE_EN enables per-bit debounce counters in niossoc_pio_debounce.
module niossoc_button_pio
  import niossoc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("niossoc_button_pio: WIDTH must be 1..32");
  end
  if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("niossoc_button_pio: EDGE_TYPE must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] clr_vec;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    niossoc_pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[i]),
      .f_bit (f[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    p_d = f;
    case (EDGE_TYPE)
      EDGE_RISE: edge_vec = f & ~p_q;
      EDGE_FALL: edge_vec = ~f & p_q;
      default:   edge_vec = f ^ p_q;
    endcase
  end

  always_comb begin
    irqmask_d = irqmask_q;
    clr_vec   = '0;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr_vec = writedata[WIDTH-1:0];
    end
    // Set is applied after the clear so a new edge survives a same-cycle W1C.
    edgecap_d = (edgecap_q & ~clr_vec) | edge_vec;
  end

  // Read mux runs every cycle regardless of chipselect; unused bits stay zero.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = f;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q        <= in_port;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      p_q        <= p_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
